traffic_lights_monitor: RTL and testbench



---
 rtl/traffic_lights_monitor_pkg.sv | 60 ++++++
 rtl/traffic_lights_monitor_rep_reg.sv | 53 +++++
 rtl/traffic_lights_monitor.sv | 168 ++++++++++++++++
 tb/tb_traffic_lights_monitor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_lights_monitor_pkg.sv
// Shared types and helpers for the traffic-light lamp-side monitor.
// Phase encoding, lamp-code constants, the lamp decoder and the phase
// successor table used by the optional sequence checker.
package traffic_lights_monitor_pkg;

   typedef enum logic [2:0] {
      PH_OFF          = 3'd0,
      PH_RED          = 3'd1,
      PH_RED_YELLOW   = 3'd2,
      PH_GREEN        = 3'd3,
      PH_GREEN_BLINK  = 3'd4,
      PH_YELLOW       = 3'd5,
      PH_YELLOW_BLINK = 3'd6,
      PH_ILLEGAL      = 3'd7
   } phase_t;

   // Lamp codes as {red, yellow, green}
   localparam logic [2:0] LAMP_OFF        = 3'b000;
   localparam logic [2:0] LAMP_RED        = 3'b100;
   localparam logic [2:0] LAMP_RED_YELLOW = 3'b110;
   localparam logic [2:0] LAMP_GREEN      = 3'b001;
   localparam logic [2:0] LAMP_YELLOW     = 3'b010;

   // Map a sampled lamp triple to the solid phase it represents.
   function automatic phase_t lamp_decode(input logic r, input logic y, input logic g);
      phase_t ph;
      case ({r, y, g})
         LAMP_OFF:        ph = PH_OFF;
         LAMP_RED:        ph = PH_RED;
         LAMP_RED_YELLOW: ph = PH_RED_YELLOW;
         LAMP_GREEN:      ph = PH_GREEN;
         LAMP_YELLOW:     ph = PH_YELLOW;
         default:         ph = PH_ILLEGAL;
      endcase
      return ph;
   endfunction

   // True when 'cur' may legally follow 'prev' as completed phases.
   // An ILLEGAL phase is flagged once; the phase after it is not re-flagged.
   function automatic logic seq_legal(input phase_t prev, input phase_t cur);
      logic ok;
      ok = 1'b0;
      if (cur == PH_ILLEGAL) begin
         ok = 1'b0;
      end else if (cur == PH_OFF || prev == PH_OFF || prev == PH_ILLEGAL) begin
         ok = 1'b1;
      end else begin
         case (prev)
            PH_RED:         ok = (cur == PH_RED_YELLOW);
            PH_RED_YELLOW:  ok = (cur == PH_GREEN);
            PH_GREEN:       ok = (cur == PH_GREEN_BLINK);
            PH_GREEN_BLINK: ok = (cur == PH_YELLOW);
            PH_YELLOW:      ok = (cur == PH_RED);
            default:        ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

endpackage

// File: rtl/traffic_lights_monitor_rep_reg.sv
// Single-entry valid/ready report holding register.
// A new report is taken when the slot is empty or being drained in the same
// cycle; otherwise it is discarded and a one-cycle drop pulse is raised.
module traffic_lights_monitor_rep_reg
   import traffic_lights_monitor_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             load,
   input  logic [2:0]       load_phase,
   input  logic [CNT_W-1:0] load_dur,
   input  logic             rdy,
   output logic             val,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] dur,
   output logic             drop
);

   logic accept;
   logic take;
   logic lost;

   // Decide whether an incoming report fits, drains, or is lost.
   always_comb begin
      accept = load & (~val | rdy);
      take   = val & rdy;
      lost   = load & val & ~rdy;
   end

   // Holding register and drop pulse.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         val   <= 1'b0;
         phase <= 3'd0;
         dur   <= '0;
         drop  <= 1'b0;
      end else begin
         drop <= lost;
         if (accept) begin
            val   <= 1'b1;
            phase <= load_phase;
            dur   <= load_dur;
         end else if (take) begin
            val <= 1'b0;
         end else begin
            val <= val;
         end
      end
   end

endmodule

// File: rtl/traffic_lights_monitor.sv
// Lamp-side observer: decodes red/yellow/green back into controller phases,
// measures each phase in clock ticks and reports every completed phase.
// Optional macro TRAFFIC_LIGHTS_MONITOR_SEQ_CHECK_EN adds seq_err_o, which
// flags a completed phase that is not a legal successor of the previous one.
module traffic_lights_monitor
   import traffic_lights_monitor_pkg::*;
#(
   parameter int CNT_W         = 16,
   parameter int BLINK_GAP_MAX = 12
) (
   input  logic             clk_i,
   input  logic             arst_ni,
   input  logic             red_i,
   input  logic             yellow_i,
   input  logic             green_i,
   output logic [2:0]       rep_phase_o,
   output logic [CNT_W-1:0] rep_dur_o,
   output logic             rep_val_o,
   input  logic             rep_rdy_i,
   output logic             rep_drop_o,
   output logic [2:0]       cur_phase_o
`ifdef TRAFFIC_LIGHTS_MONITOR_SEQ_CHECK_EN
   ,
   output logic             seq_err_o
`endif
);

   // Gap counter must reach BLINK_GAP_MAX+1 to detect the blink timeout.
   localparam int GAP_W = $clog2(BLINK_GAP_MAX + 2);
   localparam logic [CNT_W-1:0] DUR_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] DUR_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] DUR_OFF   = CNT_W'(BLINK_GAP_MAX + 1);
   localparam logic [GAP_W-1:0] GAP_ONE   = {{(GAP_W-1){1'b0}}, 1'b1};
   localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(BLINK_GAP_MAX + 1);

   phase_t           cur_phase;
   phase_t           nxt_phase;
   logic [CNT_W-1:0] dur;
   logic [CNT_W-1:0] nxt_dur;
   logic [CNT_W-1:0] dur_inc;
   logic [GAP_W-1:0] gap;
   logic [GAP_W-1:0] nxt_gap;
   logic [GAP_W-1:0] gap_inc;
   phase_t           code;
   phase_t           lit;
   logic             end_req;
   phase_t           end_phase;
   logic [CNT_W-1:0] end_dur;

   // Decode the current lamp sample and precompute saturating increments.
   always_comb begin
      code    = lamp_decode(red_i, yellow_i, green_i);
      dur_inc = (dur == DUR_MAX) ? dur : (dur + DUR_ONE);
      gap_inc = gap + GAP_ONE;
   end

   // Phase FSM: next phase, duration/gap counters and phase-end report.
   always_comb begin
      nxt_phase = cur_phase;
      nxt_dur   = dur_inc;
      nxt_gap   = gap;
      end_req   = 1'b0;
      end_phase = cur_phase;
      end_dur   = dur;
      lit       = PH_GREEN;
      case (cur_phase)
         PH_GREEN_BLINK, PH_YELLOW_BLINK: begin
            lit = (cur_phase == PH_GREEN_BLINK) ? PH_GREEN : PH_YELLOW;
            if (code == lit) begin
               nxt_gap = '0;
            end else if (code == PH_OFF) begin
               if (gap_inc == GAP_LIMIT) begin
                  // Blink stopped: report up to the last lit tick, the
                  // dark ticks already seen belong to the OFF phase.
                  end_req   = 1'b1;
                  end_dur   = dur - CNT_W'(gap);
                  nxt_phase = PH_OFF;
                  nxt_dur   = DUR_OFF;
                  nxt_gap   = '0;
               end else begin
                  nxt_gap = gap_inc;
               end
            end else begin
               end_req   = 1'b1;
               nxt_phase = code;
               nxt_dur   = DUR_ONE;
               nxt_gap   = '0;
            end
         end
         default: begin
            if (code == cur_phase) begin
               nxt_dur = dur_inc;
            end else if (cur_phase == PH_GREEN && code == PH_OFF) begin
               end_req   = 1'b1;
               nxt_phase = PH_GREEN_BLINK;
               nxt_dur   = DUR_ONE;
               nxt_gap   = GAP_ONE;
            end else if (cur_phase == PH_YELLOW && code == PH_OFF) begin
               // Yellow blink absorbs the initial lit segment, no report.
               nxt_phase = PH_YELLOW_BLINK;
               nxt_dur   = dur_inc;
               nxt_gap   = GAP_ONE;
            end else begin
               // dur==0 only right after reset: nothing was measured yet.
               end_req   = (dur != '0);
               nxt_phase = code;
               nxt_dur   = DUR_ONE;
               nxt_gap   = '0;
            end
         end
      endcase
   end

   // Phase state and counters.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         cur_phase <= PH_OFF;
         dur       <= '0;
         gap       <= '0;
      end else begin
         cur_phase <= nxt_phase;
         dur       <= nxt_dur;
         gap       <= nxt_gap;
      end
   end

   assign cur_phase_o = cur_phase;

   traffic_lights_monitor_rep_reg #(
      .CNT_W (CNT_W)
   ) u_rep_reg (
      .clk        (clk_i),
      .arst_n     (arst_ni),
      .load       (end_req),
      .load_phase (end_phase),
      .load_dur   (end_dur),
      .rdy        (rep_rdy_i),
      .val        (rep_val_o),
      .phase      (rep_phase_o),
      .dur        (rep_dur_o),
      .drop       (rep_drop_o)
   );

`ifdef TRAFFIC_LIGHTS_MONITOR_SEQ_CHECK_EN
   phase_t prev_done;
   logic   seq_err;

   // Track the last completed phase and flag illegal successions,
   // including those whose report is dropped.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         prev_done <= PH_OFF;
         seq_err   <= 1'b0;
      end else begin
         if (end_req) begin
            prev_done <= end_phase;
            seq_err   <= ~seq_legal(prev_done, end_phase);
         end else begin
            prev_done <= prev_done;
            seq_err   <= 1'b0;
         end
      end
   end

   assign seq_err_o = seq_err;
`endif

endmodule

// File: tb/tb_traffic_lights_monitor.sv
// Directed self-checking bench for traffic_lights_monitor.
module tb_traffic_lights_monitor;

   logic        clk;
   logic        arst_ni;
   logic        red;
   logic        yellow;
   logic        green;
   logic [2:0]  rep_phase;
   logic [15:0] rep_dur;
   logic        rep_val;
   logic        rep_rdy;
   logic        rep_drop;
   logic [2:0]  cur_phase;
`ifdef TRAFFIC_LIGHTS_MONITOR_SEQ_CHECK_EN
   logic        seq_err;
   int          seq_cnt = 0;
   int          seq_base;
`endif

   typedef struct packed {
      logic [2:0]  ph;
      logic [15:0] du;
   } rep_t;

   rep_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   drop_cnt = 0;

   traffic_lights_monitor #(
      .CNT_W         (16),
      .BLINK_GAP_MAX (12)
   ) dut (
      .clk_i       (clk),
      .arst_ni     (arst_ni),
      .red_i       (red),
      .yellow_i    (yellow),
      .green_i     (green),
      .rep_phase_o (rep_phase),
      .rep_dur_o   (rep_dur),
      .rep_val_o   (rep_val),
      .rep_rdy_i   (rep_rdy),
      .rep_drop_o  (rep_drop),
      .cur_phase_o (cur_phase)
`ifdef TRAFFIC_LIGHTS_MONITOR_SEQ_CHECK_EN
      ,
      .seq_err_o   (seq_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record accepted reports and pulse counts at each active edge.
   always @(posedge clk) begin
      if (arst_ni && rep_val && rep_rdy) q.push_back({rep_phase, rep_dur});
      if (rep_drop) drop_cnt++;
`ifdef TRAFFIC_LIGHTS_MONITOR_SEQ_CHECK_EN
      if (seq_err) seq_cnt++;
`endif
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic set_lamps(input logic [2:0] code, input int n);
      {red, yellow, green} = code;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_rep(input string tag, input logic [2:0] ph, input logic [15:0] du);
      rep_t r;
      check({tag, "_avail"}, 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
         r = q.pop_front();
         check({tag, "_phase"}, 32'(r.ph), 32'(ph));
         check({tag, "_dur"}, 32'(r.du), 32'(du));
      end
   endtask

   initial begin
      arst_ni = 1'b0;
      rep_rdy = 1'b1;
      {red, yellow, green} = 3'b100;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cur_phase", 32'(cur_phase), 32'd0);
      check("rst_val", 32'(rep_val), 32'd0);
      check("rst_rep_phase", 32'(rep_phase), 32'd0);
      check("rst_rep_dur", 32'(rep_dur), 32'd0);
      check("rst_drop", 32'(rep_drop), 32'd0);
      arst_ni = 1'b1;

      // Normal cycle with green blink
      set_lamps(3'b100, 20);
      check("cur_red", 32'(cur_phase), 32'd1);
      set_lamps(3'b110, 10);
      set_lamps(3'b001, 30);
      for (int i = 0; i < 5; i++) set_lamps((i % 2 == 0) ? 3'b000 : 3'b001, 10);
      check("cur_gblink", 32'(cur_phase), 32'd4);
      set_lamps(3'b010, 15);
      set_lamps(3'b100, 8);
      expect_rep("red20", 3'd1, 16'd20);
      expect_rep("ry10", 3'd2, 16'd10);
      expect_rep("g30", 3'd3, 16'd30);
      expect_rep("gb50", 3'd4, 16'd50);
      expect_rep("y15", 3'd5, 16'd15);

      // Yellow blink then timeout into OFF
      for (int i = 0; i < 6; i++) set_lamps((i % 2 == 0) ? 3'b010 : 3'b000, 10);
      check("cur_yblink", 32'(cur_phase), 32'd6);
      set_lamps(3'b000, 13);
      check("cur_off_after_timeout", 32'(cur_phase), 32'd0);
      expect_rep("red8", 3'd1, 16'd8);
      expect_rep("yb50", 3'd6, 16'd50);
      set_lamps(3'b100, 5);
      expect_rep("off23", 3'd0, 16'd23);
      check("no_drop_yet", 32'(drop_cnt), 32'd0);

      // Back-pressure: first report held, the next two dropped
      rep_rdy = 1'b0;
      set_lamps(3'b110, 5);
      set_lamps(3'b001, 5);
      set_lamps(3'b010, 5);
      check("held_val", 32'(rep_val), 32'd1);
      check("held_phase", 32'(rep_phase), 32'd1);
      check("held_dur", 32'(rep_dur), 32'd5);
      check("drop_cnt", 32'(drop_cnt), 32'd2);
      check("drop_low", 32'(rep_drop), 32'd0);
      check("q_empty_bp", 32'(q.size()), 32'd0);
      rep_rdy = 1'b1;
      set_lamps(3'b010, 2);
      check("val_drained", 32'(rep_val), 32'd0);
      expect_rep("red5_held", 3'd1, 16'd5);
      set_lamps(3'b100, 3);
      expect_rep("y7", 3'd5, 16'd7);

      // Illegal code inside red, then saturating red
`ifdef TRAFFIC_LIGHTS_MONITOR_SEQ_CHECK_EN
      seq_base = seq_cnt;
`endif
      set_lamps(3'b101, 4);
      check("cur_illegal", 32'(cur_phase), 32'd7);
      expect_rep("red3", 3'd1, 16'd3);
      set_lamps(3'b100, 70000);
      expect_rep("illegal4", 3'd7, 16'd4);
`ifdef TRAFFIC_LIGHTS_MONITOR_SEQ_CHECK_EN
      check("seq_err_illegal", 32'(seq_cnt - seq_base), 32'd1);
`endif
      set_lamps(3'b110, 4);
      expect_rep("red_sat", 3'd1, 16'd65535);

      // Asynchronous reset in the middle of green with a pending report
      rep_rdy = 1'b0;
      set_lamps(3'b001, 10);
      check("pending_val", 32'(rep_val), 32'd1);
      #3;
      arst_ni = 1'b0;
      #1;
      check("arst_cur_phase", 32'(cur_phase), 32'd0);
      check("arst_val", 32'(rep_val), 32'd0);
      check("arst_rep_phase", 32'(rep_phase), 32'd0);
      check("arst_rep_dur", 32'(rep_dur), 32'd0);
      rep_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      arst_ni = 1'b1;
      set_lamps(3'b001, 7);
      check("no_stale_val", 32'(rep_val), 32'd0);
      check("no_stale_q", 32'(q.size()), 32'd0);
      set_lamps(3'b010, 3);
      expect_rep("g7_post_rst", 3'd3, 16'd7);
      check("final_q_empty", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
